nibble_serial_adder: RTL

NIBBLE_SERIAL_ADDER -- requirements
Module: nibble_serial_adder

---
 rtl/four_bit_ripple.sv | 34 +++
 rtl/nibble_serial_adder.sv | 113 +++++++++++
 2 files changed

// File: rtl/four_bit_ripple.sv
// Four-bit ripple-carry adder: the external nibble datapath that nibble_serial_adder
// sequences through.
module four_bit_ripple (
  input  logic A0,
  input  logic A1,
  input  logic A2,
  input  logic A3,
  input  logic B0,
  input  logic B1,
  input  logic B2,
  input  logic B3,
  input  logic Cin,
  output logic S0,
  output logic S1,
  output logic S2,
  output logic S3,
  output logic C3
);

  logic c0, c1, c2;

  assign S0 = A0 ^ B0 ^ Cin;
  assign c0 = (A0 & B0) | (A0 & Cin) | (B0 & Cin);

  assign S1 = A1 ^ B1 ^ c0;
  assign c1 = (A1 & B1) | (A1 & c0) | (B1 & c0);

  assign S2 = A2 ^ B2 ^ c1;
  assign c2 = (A2 & B2) | (A2 & c1) | (B2 & c1);

  assign S3 = A3 ^ B3 ^ c2;
  assign C3 = (A3 & B3) | (A3 & c2) | (B3 & c2);

endmodule

// File: rtl/nibble_serial_adder.sv
// 16-bit adder that reuses an external four-bit ripple adder over four cycles,
// one nibble per cycle, least significant nibble first.
module nibble_serial_adder (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [15:0] op_a,
  input  logic [15:0] op_b,
  input  logic        cin,
  output logic        A0,
  output logic        A1,
  output logic        A2,
  output logic        A3,
  output logic        B0,
  output logic        B1,
  output logic        B2,
  output logic        B3,
  output logic        Cin,
  input  logic        S0,
  input  logic        S1,
  input  logic        S2,
  input  logic        S3,
  input  logic        C3,
  output logic        busy,
  output logic        done,
  output logic [15:0] sum,
  output logic        cout
);

  typedef enum logic [1:0] {
    StIdle,
    StAdd,
    StDone
  } state_e;

  state_e      state;
  logic [1:0]  nib;
  logic        carry_reg;
  logic [15:0] op_a_lat;
  logic [15:0] op_b_lat;

  logic [3:0]  nib_base;
  logic [3:0]  a_nib;
  logic [3:0]  b_nib;
  logic        cin_nib;
  logic [3:0]  s_nib;

  assign nib_base = {nib, 2'b00};
  assign s_nib    = {S3, S2, S1, S0};

  // Adder inputs are only live while adding; otherwise they sit at zero.
  always_comb begin
    a_nib   = 4'h0;
    b_nib   = 4'h0;
    cin_nib = 1'b0;
    if (state == StAdd) begin
      a_nib   = op_a_lat[nib_base +: 4];
      b_nib   = op_b_lat[nib_base +: 4];
      cin_nib = carry_reg;
    end
  end

  assign {A3, A2, A1, A0} = a_nib;
  assign {B3, B2, B1, B0} = b_nib;
  assign Cin              = cin_nib;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= StIdle;
      nib       <= 2'd0;
      carry_reg <= 1'b0;
      op_a_lat  <= 16'h0000;
      op_b_lat  <= 16'h0000;
      sum       <= 16'h0000;
      cout      <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
    end else begin
      done <= 1'b0;
      unique case (state)
        StIdle: begin
          if (start) begin
            op_a_lat  <= op_a;
            op_b_lat  <= op_b;
            carry_reg <= cin;
            nib       <= 2'd0;
            busy      <= 1'b1;
            state     <= StAdd;
          end
        end
        StAdd: begin
          sum[nib_base +: 4] <= s_nib;
          carry_reg          <= C3;
          nib                <= nib + 2'd1;
          if (nib == 2'd3) begin
            cout  <= C3;
            busy  <= 1'b0;
            done  <= 1'b1;
            state <= StDone;
          end
        end
        StDone: begin
          state <= StIdle;
        end
        default: begin
          busy  <= 1'b0;
          state <= StIdle;
        end
      endcase
    end
  end

endmodule
